addsub_seq_ctrl: RTL and testbench
==================================

// Module: addsub_seq_ctrl
// PURPOSE
//   Multi-precision add/subtract sequencer. Performs WIDTH-bit A+B or A-B over WIDTH/4 cycles.
//   Time-shares one adder_subtractor_4bit slice, one nibble per cycle, LSB first, with the carry
//   held in a register between nibbles. Ready/valid on both sides; one operation in flight.
//   Sits between an operand producer and a result consumer.
// PARAMETERS
//   WIDTH   16   operand/result width; multiple of 4, >= 4. NIB = WIDTH/4 = cycles per operation.
// PORTS
//   clk          in   1      single clock, rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   in_valid     in   1      operands valid
//   in_ready     out  1      controller can accept (state IDLE)
//   in_a         in   WIDTH  operand A
//   in_b         in   WIDTH  operand B
//   in_sub       in   1      0 = A+B, 1 = A-B
//   out_valid    out  1      result valid; held until out_ready
//   out_ready    in   1      consumer accepts result
//   out_result   out  WIDTH  A+B or A-B, mod 2^WIDTH
//   out_carry    out  1      final carry; for subtract, 1 = no borrow (A >= B unsigned)
//   out_overflow out  1      two's-complement signed overflow
//   busy         out  1      state != IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; out_valid, out_result, out_carry, out_overflow, busy = 0.
//     Operand/carry/index registers = 0. in_ready=1 (IDLE) but nothing is captured while in reset.
//   FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&&in_ready edge: latch in_a, in_b, in_sub; idx=0; go to RUN.
//   RUN: 1 cycle per nibble. Slice inputs: a=A[4*idx+:4], b=B[4*idx+:4], mode=sub.
//     Slice Cin = carry_in ^ sub. The slice XORs mode into Cin internally.
//     Nibble 0 uses carry_in=sub (so 1 for subtract); later nibbles use the carry register.
//     Each edge writes the Sum into result[4*idx+:4], registers Cout, and does idx++.
//     The edge where idx==NIB-1: go to DONE; set out_carry = final Cout.
//     Also set out_overflow = (A[MSB]==Beff[MSB]) && (R[MSB]!=A[MSB]), where Beff = B ^ {WIDTH{sub}}.
//   DONE: out_valid=1. out_result, out_carry, out_overflow are stable and do not change.
//     On out_valid&&out_ready edge: go to IDLE and clear out_valid.
//     out_result and flags hold their last value until the next operation.
//   Latency: out_valid rises exactly NIB cycles after the accept edge.
//     Minimum issue interval is NIB+2 cycles (no overlap of accept with DONE).
//   in_ready=0 in RUN and DONE. in_valid there is ignored; operands are not sampled.
//   Input operands may change after acceptance without affecting the result (latched copy).
//   out_ready held high in advance: DONE lasts exactly 1 cycle.
//   Wrap-around: result is mod 2^WIDTH. Carry/overflow are reported, never saturated.
//   rst_n asserted mid-RUN or in DONE: aborts immediately. Partial result discarded, outputs per reset.
//   WIDTH=4: RUN lasts one cycle; idx is a degenerate 1-bit counter.
// STRUCTURE
//   Package addsub_seq_pkg holds:
//     state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
//     function clog2 for idx width;
//     localparam NIB_W=4.
//   One sub-module: adder_subtractor_4bit (existing slice), instantiated once, combinational.
//   Everything else lives in this file: FSM, idx counter, operand/result shift-free indexed regs,
//   carry reg, flag logic.
// TESTING (WIDTH=16 unless noted)
//   1. add 0x1234 + 0x0FFF -> result 0x2233, carry 0, ovf 0; out_valid 4 cycles after accept.
//   2. sub 0x0005 - 0x0007 -> result 0xFFFE, carry 0 (borrow), ovf 0.
//      sub 0x0007 - 0x0005 -> 0x0002, carry 1.
//   3. add 0x7FFF + 0x0001 -> 0x8000, carry 0, ovf 1.
//      add 0xFFFF + 0x0001 -> 0x0000, carry 1, ovf 0.
//   4. sub 0x8000 - 0x0001 -> 0x7FFF, carry 1, ovf 1.
//      WIDTH=4: sub 0x3 - 0x3 -> 0x0, carry 1, 1-cycle RUN.
//   5. Backpressure: hold out_ready=0 for 5 cycles and pulse in_valid with new operands meanwhile.
//      -> result stable, in_ready=0, new operands ignored.
//      out_ready=1 -> IDLE next cycle, then next op accepted and correct.
//   6. rst_n low 1 cycle after 2 nibbles of 0xFFFF+0xFFFF.
//      -> outputs 0 asynchronously, IDLE.
//      After release, add 0x0001+0x0001 -> 0x0002, carry 0.

Source files
------------

// File: rtl/addsub_seq_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package addsub_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int NIB_W = 4;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub_seq_ctrl_if.sv
// Operand/result ready-valid bundle between producer, sequencer and consumer.
interface addsub_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_overflow;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_result, out_carry, out_overflow
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_result, out_carry, out_overflow
    );
endinterface

// File: rtl/addsub_seq_ctrl_slice.sv
// 4-bit add/subtract slice; mode inverts B and is XORed into the carry-in.
module adder_subtractor_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       mode,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] b_eff;
    logic       c_eff;

    always_comb begin
        b_eff       = b ^ {4{mode}};
        c_eff       = cin ^ mode;
        {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {4'd0, c_eff};
    end
endmodule

// File: rtl/addsub_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one 4-bit slice reused LSB-first over WIDTH/4 cycles.
module addsub_seq_ctrl
    import addsub_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    addsub_seq_ctrl_if.slave   bus,
    output logic               busy
);
    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = (NIB > 1) ? clog2(NIB) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic             cy_out_q, cy_out_d;
    logic             ovf_q, ovf_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [NIB_W-1:0] nib_a, nib_b, nib_sum;
    logic             nib_cin, nib_cout;
    logic             last;
    logic [31:0]      sh;

    // Shift-based nibble select keeps WIDTH=4 free of out-of-range part-selects.
    always_comb begin
        sh      = NIB_W * 32'(idx_q);
        nib_a   = NIB_W'(a_q >> sh);
        nib_b   = NIB_W'(b_q >> sh);
        nib_cin = ((idx_q == '0) ? sub_q : carry_q) ^ sub_q;
        last    = (idx_q == IDX_W'(NIB - 1));
    end

    adder_subtractor_4bit u_slice (
        .a    (nib_a),
        .b    (nib_b),
        .mode (sub_q),
        .cin  (nib_cin),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        res_d    = res_q;
        carry_d  = carry_q;
        cy_out_d = cy_out_q;
        ovf_d    = ovf_q;
        idx_d    = idx_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    sub_d   = bus.in_sub;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d   = (res_q & ~(WIDTH'({NIB_W{1'b1}}) << sh)) | (WIDTH'(nib_sum) << sh);
                carry_d = nib_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (last) begin
                    state_d  = S_DONE;
                    cy_out_d = nib_cout;
                    ovf_d    = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sub_q)) &&
                               (nib_sum[NIB_W-1] != a_q[WIDTH-1]);
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            cy_out_q <= 1'b0;
            ovf_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            cy_out_q <= cy_out_d;
            ovf_q    <= ovf_d;
            idx_q    <= idx_d;
        end
    end

    assign bus.in_ready     = (state_q == S_IDLE);
    assign bus.out_valid    = (state_q == S_DONE);
    assign bus.out_result   = res_q;
    assign bus.out_carry    = cy_out_q;
    assign bus.out_overflow = ovf_q;
    assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed scoreboard bench for addsub_seq_ctrl at WIDTH=16, plus a WIDTH=4 instance.
module tb_addsub_seq_ctrl;

    typedef struct packed {
        logic [15:0] r;
        logic        c;
        logic        v;
    } exp_t;

    logic clk;
    logic rst_n;
    logic busy16;
    logic busy4;
    int   checks;
    int   failures;
    exp_t sb[$];

    addsub_seq_ctrl_if #(.WIDTH(16)) bus16 ();
    addsub_seq_ctrl_if #(.WIDTH(4))  bus4 ();

    addsub_seq_ctrl #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16),
        .busy  (busy16)
    );

    addsub_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4),
        .busy  (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width two's-complement arithmetic, independent of nibble slicing.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sub);
        logic [16:0] s;
        logic [15:0] be;
        exp_t        e;
        be  = sub ? ~b : b;
        s   = {1'b0, a} + {1'b0, be} + {16'd0, sub};
        e.r = s[15:0];
        e.c = s[16];
        e.v = (a[15] == be[15]) && (s[15] != a[15]);
        return e;
    endfunction

    // hold=0: out_ready high in advance; hold>0: out_ready low for hold cycles in DONE.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input exp_t e, input int hold);
        int   k;
        exp_t got;
        k = 0;
        while (bus16.in_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " idle"}, 32'(bus16.in_ready), 32'd1);
        bus16.in_a      = a;
        bus16.in_b      = b;
        bus16.in_sub    = sub;
        bus16.in_valid  = 1'b1;
        bus16.out_ready = (hold == 0);
        @(posedge clk);
        sb.push_back(e);
        @(negedge clk);
        bus16.in_valid = 1'b0;
        bus16.in_a     = 16'($urandom);
        bus16.in_b     = 16'($urandom);
        bus16.in_sub   = ~sub;
        k = 0;
        while (bus16.out_valid !== 1'b1 && k < 20) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'd4);
        if (sb.size() == 0) begin
            chk({tag, " sb_empty"}, 32'd0, 32'd1);
            got = '0;
        end else begin
            got = sb.pop_front();
        end
        chk({tag, " result"},   32'(bus16.out_result),   32'(got.r));
        chk({tag, " carry"},    32'(bus16.out_carry),    32'(got.c));
        chk({tag, " overflow"}, 32'(bus16.out_overflow), 32'(got.v));
        for (int i = 0; i < hold; i++) begin
            bus16.in_valid = 1'b1;
            bus16.in_a     = 16'($urandom);
            bus16.in_b     = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk({tag, " bp_valid"},  32'(bus16.out_valid),  32'd1);
            chk({tag, " bp_ready"},  32'(bus16.in_ready),   32'd0);
            chk({tag, " bp_result"}, 32'(bus16.out_result), 32'(got.r));
            chk({tag, " bp_carry"},  32'(bus16.out_carry),  32'(got.c));
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " done_1cyc"}, 32'(bus16.out_valid), 32'd0);
        chk({tag, " back_idle"}, 32'(bus16.in_ready),  32'd1);
        chk({tag, " hold_res"},  32'(bus16.out_result), 32'(got.r));
        bus16.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        logic        rs;
        int          k;
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        bus16.in_valid  = 1'b0;
        bus16.in_a      = '0;
        bus16.in_b      = '0;
        bus16.in_sub    = 1'b0;
        bus16.out_ready = 1'b0;
        bus4.in_valid   = 1'b0;
        bus4.in_a       = '0;
        bus4.in_b       = '0;
        bus4.in_sub     = 1'b0;
        bus4.out_ready  = 1'b0;

        #2;
        chk("rst out_valid", 32'(bus16.out_valid),    32'd0);
        chk("rst result",    32'(bus16.out_result),   32'd0);
        chk("rst carry",     32'(bus16.out_carry),    32'd0);
        chk("rst ovf",       32'(bus16.out_overflow), 32'd0);
        chk("rst busy",      32'(busy16),             32'd0);
        chk("rst in_ready",  32'(bus16.in_ready),     32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("add1",     16'h1234, 16'h0FFF, 1'b0, '{r:16'h2233, c:1'b0, v:1'b0}, 1);
        do_op("sub_brw",  16'h0005, 16'h0007, 1'b1, '{r:16'hFFFE, c:1'b0, v:1'b0}, 0);
        do_op("sub_nobr", 16'h0007, 16'h0005, 1'b1, '{r:16'h0002, c:1'b1, v:1'b0}, 0);
        do_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, '{r:16'h8000, c:1'b0, v:1'b1}, 0);
        do_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, '{r:16'h0000, c:1'b1, v:1'b0}, 0);
        do_op("sub_ovf",  16'h8000, 16'h0001, 1'b1, '{r:16'h7FFF, c:1'b1, v:1'b1}, 0);
        do_op("bp",       16'hA5A5, 16'h5A5A, 1'b1, model(16'hA5A5, 16'h5A5A, 1'b1), 5);
        do_op("after_bp", 16'h4000, 16'h4000, 1'b0, '{r:16'h8000, c:1'b0, v:1'b1}, 0);
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            do_op("rand", ra, rb, rs, model(ra, rb, rs), i % 3);
        end

        // WIDTH=4: single-cycle RUN
        bus4.in_a     = 4'h3;
        bus4.in_b     = 4'h3;
        bus4.in_sub   = 1'b1;
        bus4.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        chk("w4 busy_run",  32'(busy4),          32'd1);
        chk("w4 not_valid", 32'(bus4.out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("w4 valid",  32'(bus4.out_valid),    32'd1);
        chk("w4 result", 32'(bus4.out_result),   32'd0);
        chk("w4 carry",  32'(bus4.out_carry),    32'd1);
        chk("w4 ovf",    32'(bus4.out_overflow), 32'd0);
        bus4.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("w4 idle", 32'(bus4.in_ready), 32'd1);
        bus4.out_ready = 1'b0;

        // Abort mid-RUN after two nibbles
        k = 0;
        while (bus16.in_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        bus16.in_a     = 16'hFFFF;
        bus16.in_b     = 16'hFFFF;
        bus16.in_sub   = 1'b0;
        bus16.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus16.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("abort busy_pre", 32'(busy16), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 32'(bus16.out_valid),    32'd0);
        chk("abort result",    32'(bus16.out_result),   32'd0);
        chk("abort carry",     32'(bus16.out_carry),    32'd0);
        chk("abort ovf",       32'(bus16.out_overflow), 32'd0);
        chk("abort busy",      32'(busy16),             32'd0);
        chk("abort in_ready",  32'(bus16.in_ready),     32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("post_rst", 16'h0001, 16'h0001, 1'b0, '{r:16'h0002, c:1'b0, v:1'b0}, 0);

        chk("sb drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
